// File: rtl/univ_rotate_seq.sv
// univ_rotate_seq
// Command sequencer for a universal rotate register. Each accepted command
// becomes one load cycle followed by i_cmd_amt rotate cycles and a one-cycle
// completion pulse. A shadow copy tracks the downstream register contents so
// that o_result matches the register while o_done is high.
//
// State table
//   state  | meaning
//   S_IDLE | waiting for a command, ctrl = hold, ready
//   S_LOAD | drive load of captured data
//   S_ROT  | drive rotate cycles, counting down remaining amount
//   S_DONE | completion pulse, ctrl = hold, ready for back-to-back command
//
// Ports
//   i_clk          rising-edge clock
//   i_async_rst_n  asynchronous active-low reset
//   i_cmd_valid    command present
//   o_cmd_ready    command accepted when valid && ready at a clock edge
//   i_cmd_dir      0 = rotate left, 1 = rotate right
//   i_cmd_amt      rotate amount, 0..DW-1
//   i_cmd_data     value loaded before rotating
//   o_ctrl         registered control code (00 load, 10 left, 01 right, 11 hold)
//   o_data         registered load data
//   o_done         one-cycle completion pulse
//   o_result       shadow register value, valid while o_done, held afterwards
module univ_rotate_seq #(
    parameter int DW = 4,
    parameter int SW = 2
) (
    input  logic          i_clk,
    input  logic          i_async_rst_n,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic          i_cmd_dir,
    input  logic [SW-1:0] i_cmd_amt,
    input  logic [DW-1:0] i_cmd_data,
    output logic [1:0]    o_ctrl,
    output logic [DW-1:0] o_data,
    output logic          o_done,
    output logic [DW-1:0] o_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ROT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] CTRL_LOAD  = 2'b00;
    localparam logic [1:0] CTRL_LEFT  = 2'b10;
    localparam logic [1:0] CTRL_RIGHT = 2'b01;
    localparam logic [1:0] CTRL_HOLD  = 2'b11;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_dir;
    logic [SW-1:0] r_amt;
    logic [SW-1:0] r_cnt;
    logic [SW-1:0] w_cnt_nxt;
    logic [DW-1:0] r_shadow;
    logic [DW-1:0] w_shadow_nxt;
    logic [1:0]    r_ctrl;
    logic [1:0]    w_ctrl_nxt;
    logic [DW-1:0] r_data;
    logic [DW-1:0] r_result;
    logic          w_hs;

    assign o_cmd_ready = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_hs        = i_cmd_valid && o_cmd_ready;
    assign o_done      = (r_state == S_DONE);
    assign o_ctrl      = r_ctrl;
    assign o_data      = r_data;
    assign o_result    = r_result;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_ctrl_nxt   = CTRL_HOLD;

        case (r_state)
            S_IDLE: begin
                if (w_hs) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                // r_data already holds the captured command data
                w_shadow_nxt = r_data;
                if (r_amt == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt   = r_amt;
                    w_state_nxt = S_ROT;
                end
            end
            S_ROT: begin
                if (r_dir) w_shadow_nxt = {r_shadow[0], r_shadow[DW-1:1]};
                else       w_shadow_nxt = {r_shadow[DW-2:0], r_shadow[DW-1]};
                w_cnt_nxt = r_cnt - SW'(1);
                if (r_cnt == SW'(1)) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (w_hs) w_state_nxt = S_LOAD;
                else      w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // ctrl is registered, so it is decoded from the state being entered
        case (w_state_nxt)
            S_LOAD:  w_ctrl_nxt = CTRL_LOAD;
            S_ROT:   w_ctrl_nxt = r_dir ? CTRL_RIGHT : CTRL_LEFT;
            default: w_ctrl_nxt = CTRL_HOLD;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_async_rst_n) begin
        if (!i_async_rst_n) begin
            r_state  <= S_IDLE;
            r_dir    <= 1'b0;
            r_amt    <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_ctrl   <= CTRL_HOLD;
            r_data   <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_ctrl   <= w_ctrl_nxt;
            // The data register doubles as the captured-data register: it is
            // written only at the handshake, which is also the LOAD entry.
            if (w_hs) begin
                r_dir  <= i_cmd_dir;
                r_amt  <= i_cmd_amt;
                r_data <= i_cmd_data;
            end
            if (w_state_nxt == S_DONE) r_result <= w_shadow_nxt;
        end
    end

endmodule

// File: tb/tb_univ_rotate_seq.sv
module tb_univ_rotate_seq;

    localparam int DW = 4;
    localparam int SW = 2;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_dir;
    logic [SW-1:0] cmd_amt;
    logic [DW-1:0] cmd_data;
    logic [1:0]    ctrl;
    logic [DW-1:0] data;
    logic          done;
    logic [DW-1:0] result;
    logic [DW-1:0] q;

    int total = 0;
    int bad   = 0;

    univ_rotate_seq #(.DW(DW), .SW(SW)) dut (
        .i_clk         (clk),
        .i_async_rst_n (rst_n),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_dir     (cmd_dir),
        .i_cmd_amt     (cmd_amt),
        .i_cmd_data    (cmd_data),
        .o_ctrl        (ctrl),
        .o_data        (data),
        .o_done        (done),
        .o_result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // downstream universal rotate register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else begin
            case (ctrl)
                2'b00:   q <= data;
                2'b10:   q <= {q[DW-2:0], q[DW-1]};
                2'b01:   q <= {q[0], q[DW-1:1]};
                default: q <= q;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge with the DUT ready. Returns in the DONE cycle.
    task automatic run_cmd(input string tag, input logic dir, input int amt,
                           input logic [DW-1:0] d, input logic [DW-1:0] exp_res);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_amt   = SW'(amt);
        cmd_data  = d;
        step();
        cmd_valid = 1'b0;
        cmd_data  = ~d;
        cmd_dir   = ~dir;
        cmd_amt   = SW'(amt + 1);
        for (int i = 0; i <= amt; i++) begin
            if (i == 0) begin
                chk({tag, " load ctrl"}, 32'(ctrl), 32'h0);
                chk({tag, " load data"}, 32'(data), 32'(d));
            end else begin
                chk({tag, " rot ctrl"}, 32'(ctrl), dir ? 32'h1 : 32'h2);
            end
            chk({tag, " busy done"}, 32'(done), 32'h0);
            chk({tag, " busy ready"}, 32'(cmd_ready), 32'h0);
            step();
        end
        chk({tag, " done ctrl"}, 32'(ctrl), 32'h3);
        chk({tag, " done"}, 32'(done), 32'h1);
        chk({tag, " result"}, 32'(result), 32'(exp_res));
        chk({tag, " q"}, 32'(q), 32'(exp_res));
        chk({tag, " done ready"}, 32'(cmd_ready), 32'h1);
    endtask

    initial begin
        logic seen_done;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_amt   = '0;
        cmd_data  = '0;
        #12;
        chk("rst ready", 32'(cmd_ready), 32'h1);
        chk("rst ctrl", 32'(ctrl), 32'h3);
        chk("rst data", 32'(data), 32'h0);
        chk("rst done", 32'(done), 32'h0);
        chk("rst result", 32'(result), 32'h0);
        rst_n = 1'b1;
        step();

        run_cmd("left1", 1'b0, 1, 4'b1001, 4'b0011);
        step();
        chk("idle ctrl", 32'(ctrl), 32'h3);
        chk("idle done", 32'(done), 32'h0);
        chk("result hold", 32'(result), 32'h3);
        chk("data hold", 32'(data), 32'h9);

        run_cmd("right3", 1'b1, 3, 4'b0001, 4'b0010);
        step();
        run_cmd("zero", 1'b0, 0, 4'b1010, 4'b1010);
        step();

        // back-to-back: second command presented right after the first handshake
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_amt   = 2'd2;
        cmd_data  = 4'b0110;
        step();
        cmd_dir   = 1'b1;
        cmd_amt   = 2'd1;
        cmd_data  = 4'b1000;
        chk("b2b load ctrl", 32'(ctrl), 32'h0);
        chk("b2b load data", 32'(data), 32'h6);
        step();
        chk("b2b rot1", 32'(ctrl), 32'h2);
        chk("b2b stall ready", 32'(cmd_ready), 32'h0);
        step();
        chk("b2b rot2", 32'(ctrl), 32'h2);
        step();
        chk("b2b done1", 32'(done), 32'h1);
        chk("b2b ctrl1", 32'(ctrl), 32'h3);
        chk("b2b result1", 32'(result), 32'h9);
        chk("b2b q1", 32'(q), 32'h9);
        step();
        cmd_valid = 1'b0;
        cmd_data  = 4'b1111;
        chk("b2b ctrl 00 next", 32'(ctrl), 32'h0);
        chk("b2b done gap", 32'(done), 32'h0);
        chk("b2b load2 data", 32'(data), 32'h8);
        step();
        chk("b2b rot right", 32'(ctrl), 32'h1);
        step();
        chk("b2b done2", 32'(done), 32'h1);
        chk("b2b result2", 32'(result), 32'h4);
        chk("b2b q2", 32'(q), 32'h4);
        step();

        // stalled command accepted in DONE with fields unchanged
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_amt   = 2'd1;
        cmd_data  = 4'b0001;
        step();
        cmd_dir   = 1'b1;
        cmd_amt   = 2'd2;
        cmd_data  = 4'b0011;
        step();
        chk("stall rot ctrl", 32'(ctrl), 32'h2);
        step();
        chk("stall done1", 32'(done), 32'h1);
        chk("stall result1", 32'(result), 32'h2);
        step();
        cmd_valid = 1'b0;
        cmd_data  = 4'b0000;
        cmd_amt   = 2'd0;
        chk("stall load data", 32'(data), 32'h3);
        step();
        chk("stall rot r1", 32'(ctrl), 32'h1);
        step();
        chk("stall rot r2", 32'(ctrl), 32'h1);
        step();
        chk("stall done2", 32'(done), 32'h1);
        chk("stall result2", 32'(result), 32'hc);
        step();

        // reset pulse during the second ROT cycle of a left-3 command
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_amt   = 2'd3;
        cmd_data  = 4'b0001;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("pre-rst ctrl", 32'(ctrl), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("mid-rst ctrl", 32'(ctrl), 32'h3);
        chk("mid-rst done", 32'(done), 32'h0);
        chk("mid-rst result", 32'(result), 32'h0);
        chk("mid-rst data", 32'(data), 32'h0);
        chk("mid-rst ready", 32'(cmd_ready), 32'h1);
        #1;
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) seen_done = 1'b1;
        end
        chk("no stray done", 32'(seen_done), 32'h0);
        run_cmd("post-rst right2", 1'b1, 2, 4'b0110, 4'b1001);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/univ_rotate_seq.md
# univ_rotate_seq

Command sequencer that drives a universal rotate register through its `ctrl`/`data` interface. Ctrl encoding: 00 = load, 10 = rotate left, 01 = rotate right, 11 = hold. The block accepts one rotate command per valid/ready handshake and expands it into a load cycle followed by N rotate cycles. It then reports completion together with a shadow copy of the value the register now holds. It sits upstream of the rotate register, on the initiator side of its control interface.

## Interface
- `DW`, 4: data width; must be a power of two, ≥ 2.
- `SW`, 2: amount width, equal to log2(DW).

- `clk`  in  1  rising-edge clock.
- `async_rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_dir`  in  1  0 = rotate left, 1 = rotate right.
- `cmd_amt`  in  SW  rotate amount, 0..DW-1.
- `cmd_data`  in  DW  value to load before rotating.
- `ctrl`  out  2  control code to the rotate register (registered).
- `data`  out  DW  load data to the rotate register (registered).
- `done`  out  1  one-cycle completion pulse.
- `result`  out  DW  shadow register value; valid while `done` = 1.

## Operation
- States: IDLE, LOAD, ROT, DONE.
- **IDLE:** `ctrl` = 11, `cmd_ready` = 1. On handshake, capture `dir`, `amt` and `cmd_data` into internal registers, then go to LOAD.
- **LOAD:** `ctrl` = 00, `data` = captured data. Shadow ← captured data at the end of the cycle.
- **LOAD exit:** if `amt` = 0, go to DONE; otherwise load the remaining-count register with `amt` and go to ROT.
- **ROT:** `ctrl` = 10 (dir = 0) or 01 (dir = 1).
  - Each cycle, rotate the shadow the same way as the register: left `{s[DW-2:0], s[DW-1]}`, right `{s[0], s[DW-1:1]}`.
  - Decrement the count each cycle; when it reaches 0, go to DONE.
- **DONE:** `ctrl` = 11, `done` = 1, `result` = shadow, `cmd_ready` = 1.
  - On handshake in DONE, go directly to LOAD (back-to-back commands).
  - Otherwise return to IDLE.
- `cmd_ready` is 1 only in IDLE and DONE; it is decoded from state.
- Command fields are sampled only at the handshake edge. Later changes to `cmd_*` have no effect on the command in flight.
- `data` holds its last loaded value outside LOAD.
- `result` holds its last value after `done` falls.
- Amount arithmetic is modulo DW, so the count never exceeds DW-1.

## Timing
- Reset values: state = IDLE, `ctrl` = 11, `data` = 0, `done` = 0, `result` = 0, shadow = 0. Consequently `cmd_ready` = 1 while `async_rst_n` = 0.
- Reset is asynchronous. Asserting it mid-command forces all outputs to their reset values immediately and drops the command in flight. No `done` is generated for that command.
- For a handshake at edge E0:
  - LOAD occupies cycle 1.
  - ROT occupies cycles 2..amt+1.
  - DONE occupies cycle amt+2.
  - Occupancy is amt+2 cycles.
- Back-to-back: a handshake in DONE puts LOAD in the very next cycle, so `ctrl` goes 11 → 00 with no idle cycle. Sustained throughput is one command per amt+2 cycles.
- Downstream register `q` equals `result` during the DONE cycle. This holds because `ctrl` and shadow change on the same edges.
- `done` is never high for two consecutive cycles. This remains true during back-to-back commands, because LOAD always separates DONEs.

## Test plan
- **Left rotate:** DW=4, left, amt=1, data 4'b1001.
  - `ctrl` sequence: 00, 10, 11.
  - `done` high in cycle 3 with `result` = 4'b0011.
  - The attached rotate register `q` = 4'b0011.
- **Right rotate:** right, amt=3, data 4'b0001.
  - `ctrl` sequence: 00, 01, 01, 01, 11.
  - `result` = 4'b0010 in cycle 5.
- **Zero amount:** amt=0, data 4'b1010.
  - `ctrl` sequence: 00, 11.
  - `done` in cycle 2 with `result` = 4'b1010.
- **Back-to-back:** hold `cmd_valid` = 1 across two commands (left 2 on 4'b0110, then right 1 on 4'b1000).
  - `result` = 4'b1001, then 4'b0100.
  - `ctrl` goes 11 → 00 directly after the first DONE.
  - `cmd_data` changed after the first handshake does not alter the first result.
- **Reset mid-ROT:** pulse `async_rst_n` low during the second ROT cycle of a left-3 command.
  - Immediately after the pulse: `ctrl` = 11, `done` = 0, `result` = 0.
  - `cmd_ready` = 1.
  - No stray `done` afterwards.
  - The next command completes correctly.
- **Stalled command:** `cmd_valid` = 1 while in ROT.
  - No capture occurs.
  - The command is accepted in DONE and its fields are used unchanged.
